// File: rtl/sys_defs.sv
// Shared types for the reservation-station bank: entry layout, tag width, zero register.
package sys_defs;
    localparam int TAG_W     = 6;
    localparam int FU_OP_W   = 4;
    localparam int PAYLOAD_W = 32;

    localparam logic [TAG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [TAG_W-1:0]     t1;
        logic [TAG_W-1:0]     t2;
        logic                 t1_ready;
        logic                 t2_ready;
        logic [TAG_W-1:0]     dest_tag;
        logic [FU_OP_W-1:0]   fu_op;
        logic [PAYLOAD_W-1:0] payload;
    } rs_entry_t;
endpackage

// File: rtl/rs_alloc.sv
// Combinational N-way allocator: each valid request slot, in ascending order,
// gets the next lowest-index free entry as a one-hot grant.
module rs_alloc #(
    parameter int DEPTH = 8,
    parameter int N     = 2
) (
    input  logic [DEPTH-1:0]        free,
    input  logic [N-1:0]            req,
    output logic [N-1:0][DEPTH-1:0] grant
);
    logic [DEPTH-1:0] avail;

    always_comb begin
        avail = free;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (avail[i] && grant[k] == '0) begin
                        grant[k][i] = 1'b1;
                    end
                end
                avail = avail & ~grant[k];
            end
        end
    end
endmodule

// File: rtl/rs_bank.sv
// Reservation-station storage bank: dispatch allocation, CDB wakeup, issue retire.
// Optional RS_CDB_BYPASS_EN folds same-cycle CDB hits into inst_req and entries.
module rs_bank
    import sys_defs::*;
#(
    parameter int DEPTH  = 8,
    parameter int N      = 2,
    parameter int CDB_SZ = 2,
    parameter int FREE_W = $clog2(DEPTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [N-1:0]                  dis_valid,
    input  rs_entry_t [N-1:0]             dis_entry,
    input  logic [CDB_SZ-1:0]             cdb_valid,
    input  logic [CDB_SZ-1:0][TAG_W-1:0]  cdb_tag,
    input  logic [DEPTH-1:0]              issued,
    output logic [DEPTH-1:0]              inst_req,
    output rs_entry_t [DEPTH-1:0]         entries,
    output logic [FREE_W-1:0]             num_free
);
    logic [DEPTH-1:0]        valid_reg;
    rs_entry_t [DEPTH-1:0]   entry_reg;
    logic [DEPTH-1:0]        t1_hit;
    logic [DEPTH-1:0]        t2_hit;
    logic [N-1:0][DEPTH-1:0] alloc;
    rs_entry_t [N-1:0]       dis_woken;

    // Zero-register tag never matches, so a tag-0 broadcast wakes nothing.
    function automatic logic cdb_match(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_SZ; c++) begin
            if (cdb_valid[c] && cdb_tag[c] == tag && tag != ZERO_REG) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign t1_hit[gi] = valid_reg[gi] & cdb_match(entry_reg[gi].t1);
            assign t2_hit[gi] = valid_reg[gi] & cdb_match(entry_reg[gi].t2);
        end
        // Incoming sources capture a same-cycle broadcast so no wakeup is lost.
        for (genvar gi = 0; gi < N; gi++) begin : g_dis
            assign dis_woken[gi] = '{
                t1:       dis_entry[gi].t1,
                t2:       dis_entry[gi].t2,
                t1_ready: dis_entry[gi].t1_ready | (dis_entry[gi].t1 == ZERO_REG)
                          | cdb_match(dis_entry[gi].t1),
                t2_ready: dis_entry[gi].t2_ready | (dis_entry[gi].t2 == ZERO_REG)
                          | cdb_match(dis_entry[gi].t2),
                dest_tag: dis_entry[gi].dest_tag,
                fu_op:    dis_entry[gi].fu_op,
                payload:  dis_entry[gi].payload
            };
        end
    endgenerate

    rs_alloc #(.DEPTH(DEPTH), .N(N)) u_alloc (
        .free  (~valid_reg),
        .req   (dis_valid),
        .grant (alloc)
    );

    always_comb begin
        entries  = entry_reg;
        inst_req = '0;
        num_free = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_CDB_BYPASS_EN
            entries[i].t1_ready = entry_reg[i].t1_ready | t1_hit[i];
            entries[i].t2_ready = entry_reg[i].t2_ready | t2_hit[i];
`endif
            inst_req[i] = valid_reg[i] & entries[i].t1_ready & entries[i].t2_ready;
            if (!valid_reg[i]) begin
                num_free = num_free + FREE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
            entry_reg <= '0;
        end else if (squash) begin
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issued[i]) begin
                    valid_reg[i] <= 1'b0;
                end else if (valid_reg[i]) begin
                    entry_reg[i].t1_ready <= entry_reg[i].t1_ready | t1_hit[i];
                    entry_reg[i].t2_ready <= entry_reg[i].t2_ready | t2_hit[i];
                end
            end
            // Allocation only targets entries free in registered state.
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (alloc[k][i]) begin
                        valid_reg[i] <= 1'b1;
                        entry_reg[i] <= dis_woken[k];
                    end
                end
            end
        end
    end

`ifdef DEBUG
    always_ff @(posedge clock) begin
        if (!reset && !squash) begin
            assert ((issued & ~inst_req) == '0);
            assert ($countones(dis_valid) <= int'(num_free));
        end
    end
`endif
endmodule

// File: tb/tb_rs_bank.sv
// Directed self-checking bench for rs_bank: reset, dispatch, wakeup, issue, reuse, squash.
module tb_rs_bank;
    import sys_defs::*;

    logic                  clock;
    logic                  reset;
    logic                  squash;
    logic [1:0]            dis_valid;
    rs_entry_t [1:0]       dis_entry;
    logic [1:0]            cdb_valid;
    logic [1:0][TAG_W-1:0] cdb_tag;
    logic [7:0]            issued;
    logic [7:0]            inst_req;
    rs_entry_t [7:0]       entries;
    logic [3:0]            num_free;

    int checks = 0;
    int errors = 0;
    logic bypass;

    rs_bank #(.DEPTH(8), .N(2), .CDB_SZ(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .dis_valid (dis_valid),
        .dis_entry (dis_entry),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .issued    (issued),
        .inst_req  (inst_req),
        .entries   (entries),
        .num_free  (num_free)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic rs_entry_t mk(input int t1, input int t2, input bit r1, input bit r2,
                                     input int dest, input int pay);
        rs_entry_t e;
        e.t1       = TAG_W'(t1);
        e.t2       = TAG_W'(t2);
        e.t1_ready = r1;
        e.t2_ready = r2;
        e.dest_tag = TAG_W'(dest);
        e.fu_op    = '0;
        e.payload  = 32'(pay);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        squash    = 1'b0;
        dis_valid = 2'b00;
        dis_entry = '0;
        cdb_valid = 2'b00;
        cdb_tag   = '0;
        issued    = 8'h00;
    endtask

    initial begin
`ifdef RS_CDB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_num_free", 64'(num_free), 64'd8);
        check("rst_inst_req", 64'(inst_req), 64'h00);
        check("rst_entries", 64'(|entries), 64'd0);

        // Two ready entries go to 0 and 1.
        dis_valid    = 2'b11;
        dis_entry[0] = mk(1, 2, 1, 1, 10, 100);
        dis_entry[1] = mk(3, 4, 1, 1, 11, 101);
        step();
        idle();
        check("dis2_inst_req", 64'(inst_req), 64'h03);
        check("dis2_num_free", 64'(num_free), 64'd6);
        check("dis2_e0_dest", 64'(entries[0].dest_tag), 64'd10);
        check("dis2_e1_dest", 64'(entries[1].dest_tag), 64'd11);

        // Only slot 1 valid: lands in entry 2; tag-0 source arrives ready.
        dis_valid    = 2'b10;
        dis_entry[1] = mk(5, 0, 0, 0, 12, 102);
        step();
        idle();
        check("c_inst_req", 64'(inst_req), 64'h03);
        check("c_t2_ready", 64'(entries[2].t2_ready), 64'd1);
        check("c_num_free", 64'(num_free), 64'd5);
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'd5;
        #1;
        check("c_bypass_req", 64'(inst_req), bypass ? 64'h07 : 64'h03);
        step();
        idle();
        check("c_woken_req", 64'(inst_req), 64'h07);

        // Entry 3 waits on 7 and 8; invalid broadcast must not wake it.
        dis_valid    = 2'b01;
        dis_entry[0] = mk(7, 8, 0, 0, 13, 103);
        step();
        idle();
        cdb_valid  = 2'b00;
        cdb_tag[0] = 6'd7;
        cdb_tag[1] = 6'd8;
        step();
        idle();
        check("d_nowake_req", 64'(inst_req), 64'h07);
        cdb_valid  = 2'b11;
        cdb_tag[0] = 6'd8;
        cdb_tag[1] = 6'd7;
        step();
        idle();
        check("d_woken_req", 64'(inst_req), 64'h0F);

        issued = 8'h03;
        step();
        idle();
        check("iss_inst_req", 64'(inst_req), 64'h0C);
        check("iss_num_free", 64'(num_free), 64'd6);

        // Dispatch t2=9 with a same-cycle broadcast of 9: lands in entry 0 ready.
        dis_valid    = 2'b01;
        dis_entry[0] = mk(0, 9, 0, 0, 14, 104);
        cdb_valid    = 2'b10;
        cdb_tag[1]   = 6'd9;
        step();
        idle();
        check("e_inst_req", 64'(inst_req), 64'h0D);
        check("e_t2_ready", 64'(entries[0].t2_ready), 64'd1);
        check("e_payload", 64'(entries[0].payload), 64'd104);

        // Fill the remaining free entries 1,4,5,6,7.
        dis_valid    = 2'b11;
        dis_entry[0] = mk(1, 1, 1, 1, 20, 0);
        dis_entry[1] = mk(1, 1, 1, 1, 21, 0);
        step();
        check("f_e1_dest", 64'(entries[1].dest_tag), 64'd20);
        check("f_e4_dest", 64'(entries[4].dest_tag), 64'd21);
        check("f_num_free", 64'(num_free), 64'd3);
        dis_entry[0] = mk(1, 1, 1, 1, 22, 0);
        dis_entry[1] = mk(1, 1, 1, 1, 23, 0);
        step();
        dis_valid    = 2'b01;
        dis_entry[0] = mk(1, 1, 1, 1, 24, 0);
        step();
        idle();
        check("full_num_free", 64'(num_free), 64'd0);
        check("full_inst_req", 64'(inst_req), 64'hFF);
        check("full_e7_dest", 64'(entries[7].dest_tag), 64'd24);

        issued = 8'h81;
        step();
        idle();
        check("i81_num_free", 64'(num_free), 64'd2);
        check("i81_inst_req", 64'(inst_req), 64'h7E);
        dis_valid    = 2'b11;
        dis_entry[0] = mk(1, 1, 1, 1, 50, 0);
        dis_entry[1] = mk(1, 1, 1, 1, 51, 0);
        step();
        idle();
        check("reuse_e0_dest", 64'(entries[0].dest_tag), 64'd50);
        check("reuse_e7_dest", 64'(entries[7].dest_tag), 64'd51);
        check("reuse_num_free", 64'(num_free), 64'd0);

        // Entry freed by a same-cycle issue is not the allocation target.
        issued = 8'h04;
        step();
        idle();
        check("i04_inst_req", 64'(inst_req), 64'hFB);
        issued       = 8'h02;
        dis_valid    = 2'b01;
        dis_entry[0] = mk(1, 1, 1, 1, 60, 0);
        step();
        idle();
        check("late_e2_dest", 64'(entries[2].dest_tag), 64'd60);
        check("late_e1_dest", 64'(entries[1].dest_tag), 64'd20);
        check("late_inst_req", 64'(inst_req), 64'hFD);
        check("late_num_free", 64'(num_free), 64'd1);

        // Squash beats dispatch.
        squash       = 1'b1;
        dis_valid    = 2'b11;
        dis_entry[0] = mk(1, 1, 1, 1, 70, 0);
        dis_entry[1] = mk(1, 1, 1, 1, 71, 0);
        step();
        idle();
        check("sq_num_free", 64'(num_free), 64'd8);
        check("sq_inst_req", 64'(inst_req), 64'h00);
        check("sq_e1_kept", 64'(entries[1].dest_tag), 64'd20);

        // Reset mid-operation wipes contents despite dispatch and CDB.
        dis_valid    = 2'b11;
        dis_entry[0] = mk(1, 1, 1, 1, 80, 0);
        dis_entry[1] = mk(1, 1, 1, 1, 81, 0);
        step();
        check("pre_rst_req", 64'(inst_req), 64'h03);
        reset      = 1'b1;
        cdb_valid  = 2'b11;
        cdb_tag[0] = 6'd1;
        step();
        idle();
        check("mid_rst_free", 64'(num_free), 64'd8);
        check("mid_rst_req", 64'(inst_req), 64'h00);
        check("mid_rst_ent", 64'(|entries), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Reservation-station storage bank for one functional-unit class; sits directly upstream of the issue selector.
- Accepts up to N dispatched instructions per cycle into free entries and captures CDB broadcasts to wake up source operands.
- Presents per-entry ready requests (`inst_req`) to the selector and retires the entries the selector grants (`all_issued_insts`).
- Reports free-entry count back to dispatch.

Parameters:
- DEPTH, 8, number of RS entries
- N, 2, max dispatches per cycle
- CDB_SZ, 2, CDB broadcasts per cycle
- TAG_W, 6, physical register tag width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears all entries
- squash  in  1  mispredict flush; invalidates every entry
- dis_valid  in  N  per-slot dispatch valid
- dis_entry  in  N x rs_entry_t  dispatched entries (src tags, src ready bits, dest tag, payload)
- cdb_valid  in  CDB_SZ  broadcast valid
- cdb_tag  in  CDB_SZ x TAG_W  broadcast physical tags
- issued  in  DEPTH  grant mask from the issue selector (its `all_issued_insts`)
- inst_req  out  DEPTH  entry valid and both sources ready
- entries  out  DEPTH x rs_entry_t  current entry contents, for the issue mux
- num_free  out  $clog2(DEPTH+1)  count of invalid entries (registered state)

Behaviour:
- State per entry: `valid`, `rs_entry_t` (includes `t1_ready`, `t2_ready`). No FSM beyond the per-entry valid bit (FREE/OCCUPIED).
- Reset, rising clock edge with reset=1:
  - all `valid` cleared and entry contents zeroed.
  - Outputs after reset: `inst_req`=0, `entries`=0, `num_free`=DEPTH.
- Outputs are combinational from registered state only:
  - `inst_req[i]` = `valid[i] & t1_ready & t2_ready`.
  - `num_free` = popcount(~`valid`).
- Issue: `issued[i]`=1 clears `valid[i]` at the next edge. Asserting `issued` on an entry with `inst_req[i]`=0 is illegal (DEBUG assertion).
- Wakeup: for each valid entry and each CDB slot with `cdb_valid`, a tag match on t1 or t2 sets the corresponding ready bit at the next edge. A match on an entry also being issued this cycle has no effect.
- Dispatch allocation:
  - Dispatch slot k (ascending, valid slots only) takes the k-th lowest-index entry that is free in registered state.
  - Entries freed by `issued` this cycle are not reusable until the next cycle.
  - Invalid dispatch slots are skipped without consuming an entry.
  - popcount(`dis_valid`) > `num_free` is illegal; dispatch guarantees it (DEBUG assertion).
- Dispatch/CDB same cycle: a dispatched source whose tag matches a valid CDB tag in that cycle is written with its ready bit set. No wakeup is lost.
- Latency:
  - dispatch → earliest `inst_req` is 1 cycle.
  - CDB → `inst_req` is 1 cycle.
  - grant → entry free is 1 cycle.
- Priority: reset > squash > (issue, wakeup, dispatch).
  - squash=1 clears all `valid` and ignores dispatch in that cycle; `num_free`=DEPTH next cycle.
  - Reset mid-operation discards everything regardless of other inputs.
- Tag 0 is the zero register: CDB tag 0 never wakes anything; dispatched tag-0 sources arrive already ready.
- Full: `num_free`=0 and `dis_valid`=0 expected. Empty: `inst_req`=0.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined:
  - `inst_req` also includes same-cycle CDB matches: `valid[i]` & (`t1_ready` | t1 hit) & (`t2_ready` | t2 hit).
  - CDB → `inst_req` latency becomes 0 cycles.
  - `entries` output presents the bypassed ready bits.
- Undefined: the 1-cycle wakeup latency above applies.

Decomposition:
- Shared package (sys_defs), defines:
  - `rs_entry_t` packed struct: t1, t2, t1_ready, t2_ready, dest_tag, fu_op, payload.
  - TAG_W.
  - ZERO_REG constant.
- One sub-module: `rs_alloc`, a combinational N-way lowest-index free-slot finder returning an N x DEPTH one-hot allocation bus.
- Popcount stays inline.

Test Plan:
- Reset, then idle → `num_free`=8, `inst_req`=0, `entries`=0.
- Dispatch 2 entries with both sources ready → entries 0,1 valid; next cycle `inst_req`=8'b0000_0011, `num_free`=6.
- Entry 2 with t1=5 not ready, `cdb_tag[0]`=5 valid one cycle later → `inst_req[2]`=1 the cycle after the broadcast (same cycle with RS_CDB_BYPASS_EN).
- Fill all 8, then `issued`=8'h81 while `dis_valid`=2'b01 → dispatch illegal; separately, `issued`=8'h81 with `dis_valid`=0 → `num_free`=2 next cycle and entry 0 reused by the following dispatch.
- Dispatch t2=9 while `cdb_tag[1]`=9 valid in the same cycle → entry ready; `inst_req` set next cycle.
- 5 entries valid, squash=1 together with `dis_valid`=2'b11 → all `valid`=0, `num_free`=8 next cycle, no dispatched entry written.
